// File: rtl/lsu_ctrl.sv
// Load/store unit controller between the EX stage, the WB stage and a fixed-latency data memory.
// Latency: accept to resp_valid is 1 cycle (error), 2 cycles (store) or RD_LAT+1 cycles (load).
// Backpressure: one request in flight; req_ready only in IDLE; the response is held until resp_ready.
module lsu_ctrl #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic [4:0]            resp_rd,
  output logic                  resp_err,
  output logic                  dm_MemRead,
  output logic                  dm_MemWrite,
  output logic [DM_ADDRESS-1:0] dm_a,
  output logic [DATA_W-1:0]     dm_wd,
  output logic [2:0]            dm_funct3,
  input  logic [DATA_W-1:0]     dm_rd
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  // WAIT lasts RD_LAT-1 cycles, so the counter starts at RD_LAT-2 and ends at zero
  localparam logic [2:0] CNT_INIT = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

  state_t                  state, state_nxt;
  logic [2:0]              cnt;
  logic                    we_q;
  logic [2:0]              f3_q;
  logic [DM_ADDRESS-1:0]   addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [4:0]              rd_q;
  logic                    err_q;
  logic [DATA_W-1:0]       rdata_q;

  logic                    accept;
  logic                    req_err;
  logic                    capture;
  logic [DATA_W-1:0]       byte_sh;
  logic [DATA_W-1:0]       half_sh;
  logic [DATA_W-1:0]       load_data;

  // address bits above the data-memory window are deliberately ignored
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:DM_ADDRESS];

  assign accept  = req_valid && req_ready;
  // dm_rd is sampled on the edge that ends the RD_LAT-th strobe cycle
  assign capture = ((state == S_ISSUE) && !we_q && (RD_LAT == 1)) ||
                   ((state == S_WAIT) && (cnt == 3'd0));

  // illegal encodings and misaligned half/word accesses, decided from the raw request
  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      3'b011, 3'b110, 3'b111: req_err = 1'b1;
      3'b001, 3'b101:         req_err = req_addr[0];
      3'b010:                 req_err = (req_addr[1:0] != 2'b00);
      default:                req_err = 1'b0;
    endcase
  end

  // lane select and sign/zero extension of the returned word
  always_comb begin
    byte_sh   = dm_rd >> {addr_q[1:0], 3'b000};
    half_sh   = dm_rd >> {addr_q[1], 4'b0000};
    load_data = dm_rd;
    case (f3_q)
      3'b000:  load_data = {{(DATA_W-8){byte_sh[7]}}, byte_sh[7:0]};
      3'b100:  load_data = {{(DATA_W-8){1'b0}}, byte_sh[7:0]};
      3'b001:  load_data = {{(DATA_W-16){half_sh[15]}}, half_sh[15:0]};
      3'b101:  load_data = {{(DATA_W-16){1'b0}}, half_sh[15:0]};
      default: load_data = dm_rd;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = req_err ? S_RESP : S_ISSUE;
      S_ISSUE: state_nxt = (we_q || (RD_LAT == 1)) ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt == 3'd0) state_nxt = S_RESP;
      S_RESP:  if (resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // latched request, wait counter and response data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= 3'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 5'd0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr[DM_ADDRESS-1:0];
        wdata_q <= req_wdata;
        rd_q    <= req_rd;
        err_q   <= req_err;
        rdata_q <= '0;
      end
      if (state == S_ISSUE)
        cnt <= CNT_INIT;
      else if ((state == S_WAIT) && (cnt != 3'd0))
        cnt <= cnt - 3'd1;
      if (capture)
        rdata_q <= load_data;
    end
  end

  // outputs: memory strobes only in ISSUE/WAIT, response only in RESP
  always_comb begin
    req_ready   = (state == S_IDLE) && reset;
    resp_valid  = 1'b0;
    resp_rdata  = '0;
    resp_rd     = 5'd0;
    resp_err    = 1'b0;
    dm_MemRead  = 1'b0;
    dm_MemWrite = 1'b0;
    dm_a        = '0;
    dm_wd       = '0;
    dm_funct3   = 3'd0;
    case (state)
      S_ISSUE: begin
        if (we_q) begin
          dm_MemWrite = 1'b1;
          dm_a        = addr_q;
          dm_wd       = wdata_q;
          dm_funct3   = f3_q;
        end else begin
          dm_MemRead  = 1'b1;
          dm_a        = {addr_q[DM_ADDRESS-1:2], 2'b00};
          dm_funct3   = 3'b010;
        end
      end
      S_WAIT: begin
        dm_MemRead = 1'b1;
        dm_a       = {addr_q[DM_ADDRESS-1:2], 2'b00};
        dm_funct3  = 3'b010;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_rd    = we_q ? 5'd0 : rd_q;
        resp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: vector table on an RD_LAT=1 instance,
// plus hand-written load-latency and reset-abort sequences on an RD_LAT=4 instance.
// Memory models return valid data only in the strobe cycle where the read latency is met.
module tb_lsu_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid, req_valid4;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_ready, resp_ready4;

  logic        req_ready, resp_valid, resp_err, dm_MemRead, dm_MemWrite;
  logic [31:0] resp_rdata, dm_wd, dm_rd;
  logic [4:0]  resp_rd;
  logic [8:0]  dm_a;
  logic [2:0]  dm_funct3;

  logic        req_ready4, resp_valid4, resp_err4, dm_MemRead4, dm_MemWrite4;
  logic [31:0] resp_rdata4, dm_wd4, dm_rd4;
  logic [4:0]  resp_rd4;
  logic [8:0]  dm_a4;
  logic [2:0]  dm_funct34;

  logic [31:0] mem1, mem4;
  int          rcnt1, rcnt4;
  int          tests, fails;

  lsu_ctrl #(.DM_ADDRESS(9), .DATA_W(32), .RD_LAT(1)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_err(resp_err),
    .dm_MemRead(dm_MemRead), .dm_MemWrite(dm_MemWrite), .dm_a(dm_a), .dm_wd(dm_wd),
    .dm_funct3(dm_funct3), .dm_rd(dm_rd)
  );

  lsu_ctrl #(.DM_ADDRESS(9), .DATA_W(32), .RD_LAT(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid4), .req_ready(req_ready4), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid4), .resp_ready(resp_ready4), .resp_rdata(resp_rdata4),
    .resp_rd(resp_rd4), .resp_err(resp_err4),
    .dm_MemRead(dm_MemRead4), .dm_MemWrite(dm_MemWrite4), .dm_a(dm_a4), .dm_wd(dm_wd4),
    .dm_funct3(dm_funct34), .dm_rd(dm_rd4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // count consecutive read-strobe cycles to know when the memory data becomes valid
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rcnt1 <= 0;
      rcnt4 <= 0;
    end else begin
      rcnt1 <= dm_MemRead  ? rcnt1 + 1 : 0;
      rcnt4 <= dm_MemRead4 ? rcnt4 + 1 : 0;
    end
  end

  assign dm_rd  = (dm_MemRead  && rcnt1 == 0) ? mem1 : 32'h5A5A5A5A;
  assign dm_rd4 = (dm_MemRead4 && rcnt4 == 3) ? mem4 : 32'h5A5A5A5A;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] mem;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
    logic [8:0]  a;
    logic [2:0]  dmf3;
    logic [31:0] wd;
    int          bp;
  } vec_t;

  function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                              logic [4:0] rd, logic [31:0] mem, logic err, logic [31:0] rdata,
                              int lat, int nrd, int nwr, logic [8:0] a, logic [2:0] dmf3,
                              logic [31:0] wd, int bp);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd; v.mem = mem;
    v.err = err; v.rdata = rdata; v.lat = lat; v.nrd = nrd; v.nwr = nwr;
    v.a = a; v.dmf3 = dmf3; v.wd = wd; v.bp = bp;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int          lat, nrd, nwr;
    logic        got;
    logic [31:0] held;
    @(negedge clk);
    check($sformatf("v%0d req_ready idle", idx), req_ready, 1'b1);
    req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    req_rd = v.rd; mem1 = v.mem; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (dm_MemRead)  nrd++;
      if (dm_MemWrite) nwr++;
      if (dm_MemRead || dm_MemWrite) begin
        check($sformatf("v%0d dm_a", idx), dm_a, v.a);
        check($sformatf("v%0d dm_funct3", idx), dm_funct3, v.dmf3);
        check($sformatf("v%0d dm_wd", idx), dm_wd, v.wd);
        check($sformatf("v%0d both strobes", idx), dm_MemRead & dm_MemWrite, 1'b0);
      end
      if (resp_valid) got = 1'b1;
    end
    check($sformatf("v%0d resp seen", idx), got, 1'b1);
    check($sformatf("v%0d latency", idx), lat, v.lat);
    check($sformatf("v%0d read cycles", idx), nrd, v.nrd);
    check($sformatf("v%0d write cycles", idx), nwr, v.nwr);
    check($sformatf("v%0d resp_rdata", idx), resp_rdata, v.rdata);
    check($sformatf("v%0d resp_err", idx), resp_err, v.err);
    if (!v.err)
      check($sformatf("v%0d resp_rd", idx), resp_rd, v.we ? 5'd0 : v.rd);
    check($sformatf("v%0d dm idle in resp", idx),
          {dm_MemRead, dm_MemWrite, dm_funct3, dm_a} | dm_wd, 32'd0);
    held = resp_rdata;
    for (int k = 0; k < v.bp; k++) begin
      @(negedge clk);
      check($sformatf("v%0d bp%0d resp_valid", idx, k), resp_valid, 1'b1);
      check($sformatf("v%0d bp%0d rdata stable", idx, k), resp_rdata, held);
      check($sformatf("v%0d bp%0d req_ready", idx, k), req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    check($sformatf("v%0d no accept during completion", idx), req_ready, 1'b0);
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d resp_valid after done", idx), resp_valid, 1'b0);
    check($sformatf("v%0d req_ready after done", idx), req_ready, 1'b1);
  endtask

  vec_t vecs[16];

  initial begin
    int   lat, nrd;
    logic got;
    int   seen;

    tests = 0; fails = 0;
    reset = 1'b0; req_valid = 1'b0; req_valid4 = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0; resp_ready = 1'b0; resp_ready4 = 1'b0;
    mem1 = 32'd0; mem4 = 32'd0;

    //            we f3      addr          wdata         rd    mem           err rdata        lat rd wr a       dmf3    wd            bp
    vecs[0]  = mk(0, 3'b010, 32'h10,       32'h0,        5'd5, 32'hDEADBEEF, 0, 32'hDEADBEEF, 2, 1, 0, 9'h010, 3'b010, 32'h0,        5);
    vecs[1]  = mk(0, 3'b000, 32'h13,       32'h0,        5'd6, 32'h80FF0102, 0, 32'hFFFFFF80, 2, 1, 0, 9'h010, 3'b010, 32'h0,        0);
    vecs[2]  = mk(0, 3'b100, 32'h13,       32'h0,        5'd7, 32'h80FF0102, 0, 32'h00000080, 2, 1, 0, 9'h010, 3'b010, 32'h0,        0);
    vecs[3]  = mk(1, 3'b001, 32'h22,       32'h0000ABCD, 5'd9, 32'h0,        0, 32'h0,        2, 0, 1, 9'h022, 3'b001, 32'h0000ABCD, 2);
    vecs[4]  = mk(0, 3'b010, 32'h06,       32'h0,        5'd3, 32'hDEADBEEF, 1, 32'h0,        1, 0, 0, 9'h000, 3'b000, 32'h0,        0);
    vecs[5]  = mk(0, 3'b011, 32'h10,       32'h0,        5'd4, 32'hDEADBEEF, 1, 32'h0,        1, 0, 0, 9'h000, 3'b000, 32'h0,        0);
    vecs[6]  = mk(0, 3'b001, 32'h12,       32'h0,        5'd8, 32'h80FF0102, 0, 32'hFFFF80FF, 2, 1, 0, 9'h010, 3'b010, 32'h0,        0);
    vecs[7]  = mk(0, 3'b101, 32'h12,       32'h0,        5'd8, 32'h80FF0102, 0, 32'h000080FF, 2, 1, 0, 9'h010, 3'b010, 32'h0,        0);
    vecs[8]  = mk(0, 3'b000, 32'h11,       32'h0,        5'd1, 32'h80FF0102, 0, 32'h00000001, 2, 1, 0, 9'h010, 3'b010, 32'h0,        0);
    vecs[9]  = mk(0, 3'b100, 32'h10,       32'h0,        5'd2, 32'h80FF0102, 0, 32'h00000002, 2, 1, 0, 9'h010, 3'b010, 32'h0,        0);
    vecs[10] = mk(0, 3'b001, 32'h13,       32'h0,        5'd2, 32'h80FF0102, 1, 32'h0,        1, 0, 0, 9'h000, 3'b000, 32'h0,        0);
    vecs[11] = mk(1, 3'b010, 32'h204,      32'hCAFEF00D, 5'd1, 32'h0,        0, 32'h0,        2, 0, 1, 9'h004, 3'b010, 32'hCAFEF00D, 0);
    vecs[12] = mk(0, 3'b010, 32'hFFFF0018, 32'h0,        5'd31,32'h12345678, 0, 32'h12345678, 2, 1, 0, 9'h018, 3'b010, 32'h0,        0);
    vecs[13] = mk(1, 3'b000, 32'h03,       32'h12345678, 5'd0, 32'h0,        0, 32'h0,        2, 0, 1, 9'h003, 3'b000, 32'h12345678, 0);
    vecs[14] = mk(1, 3'b111, 32'h10,       32'h11111111, 5'd0, 32'h0,        1, 32'h0,        1, 0, 0, 9'h000, 3'b000, 32'h0,        0);
    vecs[15] = mk(1, 3'b010, 32'h21,       32'h22222222, 5'd0, 32'h0,        1, 32'h0,        1, 0, 0, 9'h000, 3'b000, 32'h0,        0);

    // reset state while reset is held low
    #12;
    check("rst req_ready", req_ready, 1'b0);
    check("rst resp_valid", resp_valid, 1'b0);
    check("rst resp fields", resp_rdata | {27'd0, resp_rd} | {31'd0, resp_err}, 32'd0);
    check("rst dm strobes", {dm_MemRead, dm_MemWrite}, 2'b00);
    check("rst dm fields", {dm_funct3, dm_a} | dm_wd, 32'd0);
    check("rst req_ready4", req_ready4, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post-reset req_ready", req_ready, 1'b1);

    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

    // RD_LAT=4 load: four strobe cycles, response after five
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_rd = 5'd12;
    mem4 = 32'hA5C3_1234; req_valid4 = 1'b1;
    @(posedge clk);
    #1 req_valid4 = 1'b0;
    lat = 0; nrd = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (dm_MemRead4) begin
        nrd++;
        check("lat4 dm_a", dm_a4, 9'h010);
      end
      if (resp_valid4) got = 1'b1;
    end
    check("lat4 resp seen", got, 1'b1);
    check("lat4 latency", lat, 5);
    check("lat4 read cycles", nrd, 4);
    check("lat4 resp_rdata", resp_rdata4, 32'hA5C31234);
    check("lat4 resp_rd", resp_rd4, 5'd12);
    resp_ready4 = 1'b1;
    @(posedge clk);
    #1 resp_ready4 = 1'b0;

    // reset in WAIT aborts the load without a response
    @(negedge clk);
    check("abort req_ready4", req_ready4, 1'b1);
    req_addr = 32'h20; mem4 = 32'h0BAD0BAD; req_valid4 = 1'b1;
    @(posedge clk);
    #1 req_valid4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort strobe in wait", dm_MemRead4, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("abort strobe dropped", dm_MemRead4, 1'b0);
    check("abort dm_a cleared", dm_a4, 9'h000);
    check("abort resp_valid", resp_valid4, 1'b0);
    check("abort req_ready in reset", req_ready4, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort req_ready after release", req_ready4, 1'b1);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid4 || dm_MemRead4) seen++;
    end
    check("abort no response", seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
